// File: rtl/lsu_mem_access_if.sv
// Word-wide data-memory bus between the load/store unit (master) and memory (slave).
// Handshake: dmem_req is held with address/strobes/data stable until a cycle with dmem_gnt;
// read data is accepted in the first cycle with dmem_rvalid after (or together with) the grant.
interface lsu_mem_access_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/lsu_mem_access.sv
// Memory-stage load/store unit: one access at a time over a req/gnt/rvalid bus,
// byte-lane store formatting, load extraction/extension and a registered response.
module lsu_mem_access #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             mem_we,
    input  logic             mem_re,
    input  logic [2:0]       mem_size,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    input  logic [4:0]       rd_in,
    input  logic             rd_wen_in,
    lsu_mem_access_if.master dmem,
    output logic             resp_valid,
    output logic [31:0]      resp_rdata,
    output logic [4:0]       resp_rd,
    output logic             resp_wen,
    output logic             misalign,
    output logic             bus_err,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

    localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  size_q, size_d;
    logic [4:0]  rd_q, rd_d;
    logic        wen_q, wen_d;
    logic        we_q, we_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic [4:0]  resp_rd_q, resp_rd_d;
    logic        resp_wen_q, resp_wen_d;
    logic        misalign_q, misalign_d;
    logic        bus_err_q, bus_err_d;

    logic        accept;
    logic        mis_in;
    logic [3:0]  strb;
    logic [31:0] lane_wdata;

    // size[0]=sub-word, size[1]=byte/half, size[2]=sign-extend
    function automatic logic [31:0] extract(input logic [31:0] data, input logic [1:0] off,
                                            input logic [2:0] size);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = data[7:0];
            2'd1:    b = data[15:8];
            2'd2:    b = data[23:16];
            default: b = data[31:24];
        endcase
        h = off[1] ? data[31:16] : data[15:0];
        if (!size[0])
            return data;
        else if (size[1])
            return {{24{size[2] & b[7]}}, b};
        else
            return {{16{size[2] & h[15]}}, h};
    endfunction

    always_comb begin
        mis_in = 1'b0;
        if (mem_size[0])
            mis_in = !mem_size[1] && addr[0];
        else
            mis_in = (addr[1:0] != 2'b00);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        accept       = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_rd_d    = resp_rd_q;
        resp_wen_d   = resp_wen_q;
        misalign_d   = misalign_q;
        bus_err_d    = bus_err_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (mis_in) begin
                        state_d      = S_RESP;
                        resp_rdata_d = 32'h0;
                        resp_rd_d    = rd_in;
                        resp_wen_d   = 1'b0;
                        misalign_d   = 1'b1;
                        bus_err_d    = 1'b0;
                    end else if (!mem_we && !mem_re) begin
                        state_d      = S_RESP;
                        resp_rdata_d = 32'h0;
                        resp_rd_d    = rd_in;
                        resp_wen_d   = rd_wen_in;
                        misalign_d   = 1'b0;
                        bus_err_d    = 1'b0;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (dmem.dmem_gnt) begin
                    if (we_q || dmem.dmem_rvalid) begin
                        state_d      = S_RESP;
                        resp_rdata_d = we_q ? 32'h0 : extract(dmem.dmem_rdata, addr_q[1:0], size_q);
                        resp_rd_d    = rd_q;
                        resp_wen_d   = wen_q;
                        misalign_d   = 1'b0;
                        bus_err_d    = 1'b0;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 8'd0;
                    end
                end
            end
            S_WAIT: begin
                // rvalid is checked first so it wins over a simultaneous timeout
                if (dmem.dmem_rvalid) begin
                    state_d      = S_RESP;
                    resp_rdata_d = extract(dmem.dmem_rdata, addr_q[1:0], size_q);
                    resp_rd_d    = rd_q;
                    resp_wen_d   = wen_q;
                    misalign_d   = 1'b0;
                    bus_err_d    = 1'b0;
                end else if (cnt_q + 8'd1 == TMO) begin
                    state_d      = S_RESP;
                    resp_rdata_d = 32'h0;
                    resp_rd_d    = rd_q;
                    resp_wen_d   = 1'b0;
                    misalign_d   = 1'b0;
                    bus_err_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_d  = accept ? addr : addr_q;
        wdata_d = accept ? wdata : wdata_q;
        size_d  = accept ? mem_size : size_q;
        rd_d    = accept ? rd_in : rd_q;
        wen_d   = accept ? rd_wen_in : wen_q;
        we_d    = accept ? mem_we : we_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            size_q       <= 3'b000;
            rd_q         <= 5'd0;
            wen_q        <= 1'b0;
            we_q         <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_rd_q    <= 5'd0;
            resp_wen_q   <= 1'b0;
            misalign_q   <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            rd_q         <= rd_d;
            wen_q        <= wen_d;
            we_q         <= we_d;
            resp_rdata_q <= resp_rdata_d;
            resp_rd_q    <= resp_rd_d;
            resp_wen_q   <= resp_wen_d;
            misalign_q   <= misalign_d;
            bus_err_q    <= bus_err_d;
        end
    end

    // Store lane formatting works off the latched request so the bus stays stable until grant
    always_comb begin
        strb       = 4'b1111;
        lane_wdata = wdata_q;
        if (size_q[0]) begin
            if (size_q[1]) begin
                strb       = 4'b0001 << addr_q[1:0];
                lane_wdata = {4{wdata_q[7:0]}};
            end else begin
                strb       = addr_q[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata_q[15:0]}};
            end
        end
    end

    assign req_ready       = (state_q == S_IDLE);
    assign dmem.dmem_req   = (state_q == S_REQ);
    assign dmem.dmem_we    = (state_q == S_REQ) && we_q;
    assign dmem.dmem_addr  = {addr_q[31:2], 2'b00};
    assign dmem.dmem_wstrb = ((state_q == S_REQ) && we_q) ? strb : 4'b0000;
    assign dmem.dmem_wdata = lane_wdata;

    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_rd    = resp_rd_q;
    assign resp_wen   = resp_wen_q;
    assign misalign   = misalign_q;
    assign bus_err    = bus_err_q;
    assign dbg_state  = state_q;

endmodule

// File: doc/lsu_mem_access.md
Name: lsu_mem_access

Overview:
- Load/store unit at the memory stage of the pipeline. It is the consumer end of the decode-side access controls: mem_we, mem_re and the mem_size encoding.
- Takes one access request at a time and drives a word-wide data-memory bus with a req/gnt/rvalid handshake.
- Generates byte strobes and lane-replicated store data, then extracts and extends load data.
- Returns a registered one-cycle response carrying the destination register tag toward writeback.

Parameters:
- TIMEOUT_CYCLES, 255, maximum cycles spent in WAIT for rvalid before reporting bus_err. Legal range 1..255; the counter is 8 bits wide.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  access request present
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid&req_ready
- mem_we  in  1  store
- mem_re  in  1  load
- mem_size  in  3  [0]=sub-word, [1]=byte(1)/half(0), [2]=sign-extend (loads only)
- addr  in  32  byte address
- wdata  in  32  store data, LSB-aligned
- rd_in  in  5  destination register tag
- rd_wen_in  in  1  register write enable tag
- dmem_req  out  1  bus request
- dmem_we  out  1  bus write
- dmem_addr  out  32  word address, {addr[31:2],2'b00}
- dmem_wstrb  out  4  byte strobes
- dmem_wdata  out  32  lane-replicated store data
- dmem_gnt  in  1  request granted this cycle
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read data
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and no-ops
- resp_rd  out  5  latched rd_in
- resp_wen  out  1  latched rd_wen_in, forced 0 on misalign/bus_err
- misalign  out  1  qualifies resp_valid
- bus_err  out  1  qualifies resp_valid

Behaviour:
- Reset values: all outputs 0 except req_ready=1; state IDLE; timeout counter 0.
- Reset mid-operation aborts any transfer: dmem_req drops asynchronously and no response is issued.
- States: IDLE, REQ, WAIT, RESP.
- On acceptance, register addr, wdata, size, tags, and we/re.
  - mem_we has priority if both mem_we and mem_re are set.
  - Misalignment: half with addr[0]=1, or word with addr[1:0]!=0. Go to RESP with misalign=1; no bus activity.
  - Neither we nor re (no-op): go to RESP, rdata=0.
  - Otherwise go to REQ.
- REQ:
  - dmem_req=1; dmem_addr, dmem_we, dmem_wstrb and dmem_wdata are held stable until gnt.
  - On gnt, a store goes to RESP.
  - On gnt, a load goes to WAIT, or directly to RESP if dmem_rvalid arrives in the same cycle.
  - No timeout applies in REQ.
- WAIT:
  - dmem_req=0; the counter increments each cycle.
  - On rvalid, capture data and go to RESP.
  - When the counter reaches TIMEOUT_CYCLES without rvalid, go to RESP with bus_err=1 and rdata=0.
  - rvalid wins if it arrives in the same cycle as the timeout.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. The counter clears and resp_* outputs hold their values until the next response.
- Latency (acceptance at cycle 0):
  - dmem_req first high in cycle 1.
  - Store with gnt in cycle 1: resp_valid in cycle 2.
  - Load with gnt in cycle 1 and rvalid in cycle 2: resp_valid in cycle 3.
  - Misaligned access or no-op: resp_valid in cycle 1.
- Store lanes, where off=addr[1:0]:
  - Byte: wdata={4{wdata[7:0]}}, wstrb=4'b0001<<off.
  - Half: wdata={2{wdata[15:0]}}, wstrb=off[1]?4'b1100:4'b0011.
  - Word: wdata passes through, wstrb=4'b1111.
- Load lanes: select byte lane off or half lane off[1]. Sign-extend if mem_size[2], else zero-extend. Word passes through.
- Stray inputs: dmem_rvalid outside WAIT/REQ and dmem_gnt outside REQ are ignored. req_valid while not IDLE is ignored (req_ready=0).

Test Plan:
- SW: addr=0x1000_0004, wdata=0xDEADBEEF, gnt in cycle 1.
  -> dmem_addr=0x1000_0004, wstrb=1111, wdata=0xDEADBEEF, resp_valid in cycle 2, resp_rdata=0.
- SB: addr=0x103, wdata=0x000000A5.
  -> dmem_addr=0x100, wstrb=1000, wdata=0xA5A5A5A5.
- SH: addr=0x102, wdata=0x00001234, gnt delayed 3 cycles.
  -> wstrb=1100, wdata=0x12341234 held stable with dmem_req=1 for 4 cycles.
- LB/LBU: addr=0x201, rdata=0x0000_8000, size=111 then 011.
  -> resp_rdata=0xFFFFFF80, then 0x00000080.
- LH, rd_in=5: addr=0x203, size=101.
  -> no dmem_req; resp_valid in cycle 1 with misalign=1, resp_wen=0, resp_rd=5.
- LW, TIMEOUT_CYCLES=4: no rvalid.
  -> bus_err=1 and resp_rdata=0 on the response after 4 WAIT cycles.
- LW with rvalid in the same cycle as gnt: resp_valid the next cycle.
- Reset asserted in WAIT: dmem_req=0, no response, and a late rvalid is ignored.
